// File: rtl/rx_deframer.sv
// rx_deframer: HDLC receive deframer (flag/abort detection, zero de-stuffing, byte assembly).
// Define RX_FRAME_ERROR_EN to add Rx_FrameError on flags that end a frame mid-byte.
module rx_deframer (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       RxEN,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_ValidFrame,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_StartFCS,
    output logic       Rx_StopFCS,
    output logic       ZeroDetect,
    output logic       Rx_FrameError
);
    typedef enum logic [1:0] {HUNT, SYNC, DATA} stateT;
    stateT state, stateNext;
    logic [7:0] raw, mask, shiftReg, rawNext, shiftNext;
    logic [2:0] fillCnt, rawOnes, ones, bitCnt, bitNext;
    logic flag, abort, stuffed, keep, byteDone, startNext, stopNext, zeroNext;

    // raw[0] is the bit about to leave; it reaches the data path only if mask[0] is set
    always_comb begin
        rawNext   = {Rx, raw[7:1]};
        flag      = RxEN && fillCnt == 3'd7 && rawNext == 8'h7E;
        abort     = RxEN && Rx && rawOnes == 3'd6;
        stuffed   = mask[0] && !raw[0] && ones == 3'd5;
        keep      = RxEN && mask[0] && !stuffed;
        bitNext   = keep ? bitCnt + 3'd1 : bitCnt;
        byteDone  = keep && bitCnt == 3'd7 && state == DATA && !abort;
        shiftNext = keep ? {raw[0], shiftReg[7:1]} : shiftReg;
        startNext = RxEN && !abort && !flag && state == SYNC && mask[0];
        stopNext  = flag && state == DATA;
        zeroNext  = RxEN && stuffed && !abort;
        stateNext = abort ? HUNT : flag ? SYNC : startNext ? DATA : state;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            state <= HUNT;
        else
            state <= stateNext;
    end

    assign Rx_ValidFrame = state == DATA;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            raw            <= '0;
            mask           <= '0;
            shiftReg       <= '0;
            fillCnt        <= '0;
            rawOnes        <= '0;
            ones           <= '0;
            bitCnt         <= '0;
            Rx_Data        <= '0;
            Rx_NewByte     <= 1'b0;
            Rx_FlagDetect  <= 1'b0;
            Rx_AbortDetect <= 1'b0;
            Rx_StartFCS    <= 1'b0;
            Rx_StopFCS     <= 1'b0;
            ZeroDetect     <= 1'b0;
        end else begin
            Rx_NewByte     <= byteDone;
            Rx_FlagDetect  <= flag;
            Rx_AbortDetect <= abort;
            Rx_StartFCS    <= startNext;
            Rx_StopFCS     <= stopNext;
            ZeroDetect     <= zeroNext;
            if (byteDone)
                Rx_Data <= shiftNext;
            if (RxEN) begin
                raw      <= rawNext;
                shiftReg <= shiftNext;
                fillCnt  <= fillCnt == 3'd7 ? fillCnt : fillCnt + 3'd1;
                rawOnes  <= !Rx ? 3'd0 : rawOnes == 3'd7 ? rawOnes : rawOnes + 3'd1;
                mask     <= (flag || abort) ? 8'h00 : {state != HUNT, mask[7:1]};
                ones     <= (flag || abort) ? 3'd0 : !mask[0] ? ones : raw[0] ? ones + 3'd1 : 3'd0;
                bitCnt   <= (flag || abort) ? 3'd0 : bitNext;
            end
        end
    end

`ifdef RX_FRAME_ERROR_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            Rx_FrameError <= 1'b0;
        else
            Rx_FrameError <= stopNext && bitNext != 3'd0;
    end
`else
    assign Rx_FrameError = 1'b0;
`endif
endmodule
